store_write_unit: RTL and testbench

// - Sink end of the store-queue commit port. Accepts committed stores (valid/addr/data/wmask) and applies backpressure via OUT_disable.
// - Stores with addr[31:24]!=8'hff go to a DEPTH-entry write buffer, which drains into the data-SRAM write port.
// - Stores with addr[31:24]==8'hff are MMIO/CSR writes. They use a req/ack handshake and drive OUT_IO_busy back to the store queue.

---
 rtl/store_write_unit.sv | 104 ++++++++++
 tb/tb_store_write_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/store_write_unit.sv
// store_write_unit: store-commit sink; SRAM write buffer plus ordered MMIO req/ack path (STORE_MERGE_EN enables tail-entry merging)
module store_write_unit #(
  parameter int DEPTH = 4,
  parameter logic [7:0] IO_PREFIX = 8'hff
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        IN_stValid,
  input  logic [31:0] IN_stAddr,
  input  logic [31:0] IN_stData,
  input  logic [3:0]  IN_stMask,
  output logic        OUT_disable,
  output logic        OUT_IO_busy,
  output logic        OUT_memWrEn,
  output logic [29:0] OUT_memAddr,
  output logic [31:0] OUT_memData,
  output logic [3:0]  OUT_memMask,
  input  logic        IN_memStall,
  output logic        OUT_ioReq,
  output logic [31:0] OUT_ioAddr,
  output logic [31:0] OUT_ioData,
  output logic [3:0]  OUT_ioMask,
  input  logic        IN_ioAck
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, DRAIN, REQ} state_t;
  state_t state, state_nxt;
  logic [29:0] buf_addr [DEPTH];
  logic [31:0] buf_data [DEPTH];
  logic [3:0]  buf_mask [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic [29:0] io_addr;
  logic is_io, merge_hit, accept, push, pop;
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^IN_stAddr[1:0];
  assign is_io = IN_stAddr[31:24] == IO_PREFIX;
`ifdef STORE_MERGE_EN
  logic [AW-1:0] tail;
  assign tail = wr_ptr - AW'(1);
  assign merge_hit = !is_io && count != 0 && buf_addr[tail] == IN_stAddr[31:2] && !(count == 1 && OUT_memWrEn);
`else
  assign merge_hit = 1'b0;
`endif
  assign OUT_disable = rst_n && IN_stValid && (is_io ? state != IDLE : (count == (AW+1)'(DEPTH) && !merge_hit));
  assign accept = IN_stValid && !OUT_disable;
  assign push = accept && !is_io && !merge_hit;
  assign pop = OUT_memWrEn;
  assign OUT_memWrEn = count != 0 && !IN_memStall;
  assign OUT_memAddr = buf_addr[rd_ptr];
  assign OUT_memData = buf_data[rd_ptr];
  assign OUT_memMask = buf_mask[rd_ptr];
  assign OUT_ioReq = state == REQ;
  assign OUT_ioAddr = {io_addr, 2'b00};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      rd_ptr <= rd_ptr + AW'(pop);
      wr_ptr <= wr_ptr + AW'(push);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      buf_addr[wr_ptr] <= IN_stAddr[31:2];
      buf_data[wr_ptr] <= IN_stData;
      buf_mask[wr_ptr] <= IN_stMask;
    end
`ifdef STORE_MERGE_EN
    if (accept && merge_hit) begin
      for (int b = 0; b < 4; b++)
        if (IN_stMask[b]) buf_data[tail][8*b +: 8] <= IN_stData[8*b +: 8];
      buf_mask[tail] <= buf_mask[tail] | IN_stMask;
    end
`endif
  end
  // MMIO waits in DRAIN until every older SRAM store has left the buffer
  always_comb begin
    state_nxt = state;
    if (state == IDLE && accept && is_io) state_nxt = DRAIN;
    if (state == DRAIN && count == 0) state_nxt = REQ;
    if (state == REQ && IN_ioAck) state_nxt = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      OUT_IO_busy <= 1'b0;
      io_addr <= '0;
      OUT_ioData <= '0;
      OUT_ioMask <= '0;
    end else begin
      state <= state_nxt;
      OUT_IO_busy <= state_nxt != IDLE;
      if (state == IDLE && accept && is_io) begin
        io_addr <= IN_stAddr[31:2];
        OUT_ioData <= IN_stData;
        OUT_ioMask <= IN_stMask;
      end
    end
  end
endmodule

// File: tb/tb_store_write_unit.sv
// tb_store_write_unit: directed vector table plus hand-written MMIO, reset and merge sequences
module tb_store_write_unit;
  logic clk = 1'b0, rst_n = 1'b0;
  logic st_valid, mem_stall, io_ack;
  logic [31:0] st_addr, st_data;
  logic [3:0] st_mask;
  logic dis, io_busy, mem_we, io_req;
  logic [29:0] mem_addr;
  logic [31:0] mem_data, io_addr, io_data;
  logic [3:0] mem_mask, io_mask;
  int ncmp = 0, nfail = 0;
  store_write_unit dut (
    .clk(clk), .rst_n(rst_n),
    .IN_stValid(st_valid), .IN_stAddr(st_addr), .IN_stData(st_data), .IN_stMask(st_mask),
    .OUT_disable(dis), .OUT_IO_busy(io_busy),
    .OUT_memWrEn(mem_we), .OUT_memAddr(mem_addr), .OUT_memData(mem_data), .OUT_memMask(mem_mask),
    .IN_memStall(mem_stall),
    .OUT_ioReq(io_req), .OUT_ioAddr(io_addr), .OUT_ioData(io_data), .OUT_ioMask(io_mask),
    .IN_ioAck(io_ack)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic v; logic [31:0] a, d; logic [3:0] m; logic st, ack;
    logic dis, we; logic [29:0] ma; logic [31:0] md; logic [3:0] mm; logic rq, busy;
  } vec_t;
  vec_t tbl [19];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m, input logic st, input logic ack);
    st_valid = v; st_addr = a; st_data = d; st_mask = m; mem_stall = st; io_ack = ack;
    #1;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tbl[0]  = '{1, 32'h1004, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 30'h0, 32'h0, 4'h0, 0, 0};
    tbl[1]  = '{0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 1, 30'h401, 32'hDEADBEEF, 4'hF, 0, 0};
    tbl[2]  = '{0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 0, 30'h0, 32'h0, 4'h0, 0, 0};
    tbl[3]  = '{1, 32'h100, 32'h11111111, 4'hF, 1, 0, 0, 0, 30'h0, 32'h0, 4'h0, 0, 0};
    tbl[4]  = '{1, 32'h104, 32'h22222222, 4'h3, 1, 0, 0, 0, 30'h0, 32'h0, 4'h0, 0, 0};
    tbl[5]  = '{1, 32'h108, 32'h33333333, 4'hC, 1, 0, 0, 0, 30'h0, 32'h0, 4'h0, 0, 0};
    tbl[6]  = '{1, 32'h10C, 32'h44444444, 4'h1, 1, 0, 0, 0, 30'h0, 32'h0, 4'h0, 0, 0};
    tbl[7]  = '{1, 32'h110, 32'h55555555, 4'hF, 1, 0, 1, 0, 30'h0, 32'h0, 4'h0, 0, 0};
    tbl[8]  = '{1, 32'h110, 32'h55555555, 4'hF, 0, 0, 1, 1, 30'h40, 32'h11111111, 4'hF, 0, 0};
    tbl[9]  = '{1, 32'h110, 32'h55555555, 4'hF, 0, 0, 0, 1, 30'h41, 32'h22222222, 4'h3, 0, 0};
    tbl[10] = '{0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 1, 30'h42, 32'h33333333, 4'hC, 0, 0};
    tbl[11] = '{0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 1, 30'h43, 32'h44444444, 4'h1, 0, 0};
    tbl[12] = '{0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 1, 30'h44, 32'h55555555, 4'hF, 0, 0};
    tbl[13] = '{0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 0, 30'h0, 32'h0, 4'h0, 0, 0};
    tbl[14] = '{1, 32'h200, 32'h0000AAAA, 4'h0, 0, 0, 0, 0, 30'h0, 32'h0, 4'h0, 0, 0};
    tbl[15] = '{0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 1, 30'h80, 32'h0000AAAA, 4'h0, 0, 0};
    tbl[16] = '{0, 32'h0, 32'h0, 4'h0, 0, 1, 0, 0, 30'h0, 32'h0, 4'h0, 0, 0};
    tbl[17] = '{1, 32'hFEFFFFFC, 32'h12345678, 4'hF, 0, 0, 0, 0, 30'h0, 32'h0, 4'h0, 0, 0};
    tbl[18] = '{0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 1, 30'h3FBFFFFF, 32'h12345678, 4'hF, 0, 0};
    drive(1, 32'hFF000000, 32'h0, 4'h0, 0, 0);
    tick;
    tick;
    chk("rst_disable", dis, 0);
    chk("rst_busy", io_busy, 0);
    chk("rst_memwe", mem_we, 0);
    chk("rst_ioreq", io_req, 0);
    chk("rst_ioaddr", io_addr, 0);
    chk("rst_iodata", io_data, 0);
    chk("rst_iomask", io_mask, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].m, tbl[i].st, tbl[i].ack);
      chk($sformatf("vec%0d_disable", i), dis, tbl[i].dis);
      chk($sformatf("vec%0d_memwe", i), mem_we, tbl[i].we);
      if (tbl[i].we) begin
        chk($sformatf("vec%0d_memaddr", i), mem_addr, tbl[i].ma);
        chk($sformatf("vec%0d_memdata", i), mem_data, tbl[i].md);
        chk($sformatf("vec%0d_memmask", i), mem_mask, tbl[i].mm);
      end
      chk($sformatf("vec%0d_ioreq", i), io_req, tbl[i].rq);
      chk($sformatf("vec%0d_busy", i), io_busy, tbl[i].busy);
      tick;
    end
    drive(1, 32'h300, 32'h1, 4'hF, 1, 0);
    tick;
    drive(1, 32'h304, 32'h2, 4'hF, 1, 0);
    tick;
    drive(1, 32'hFF000010, 32'h5A, 4'h1, 1, 0);
    chk("io_accept_disable", dis, 0);
    chk("io_accept_busy", io_busy, 0);
    tick;
    for (int i = 0; i < 3; i++) begin
      drive(0, 32'h0, 32'h0, 4'h0, 1, 0);
      chk("order_stall_busy", io_busy, 1);
      chk("order_stall_ioreq", io_req, 0);
      chk("order_stall_memwe", mem_we, 0);
      tick;
    end
    drive(0, 32'h0, 32'h0, 4'h0, 0, 0);
    chk("order_w1_memaddr", mem_addr, 30'hC0);
    chk("order_w1_memwe", mem_we, 1);
    chk("order_w1_ioreq", io_req, 0);
    tick;
    chk("order_w2_memaddr", mem_addr, 30'hC1);
    chk("order_w2_memwe", mem_we, 1);
    chk("order_w2_ioreq", io_req, 0);
    tick;
    chk("order_drain_ioreq", io_req, 0);
    chk("order_drain_memwe", mem_we, 0);
    tick;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) drive(1, 32'h400, 32'h77, 4'hF, 0, 0);
      else drive(i != 2, 32'hFF000020, 32'hA5, 4'h3, 0, 0);
      chk("hold_ioreq", io_req, 1);
      chk("hold_ioaddr", io_addr, 32'hFF000010);
      chk("hold_iodata", io_data, 32'h5A);
      chk("hold_iomask", io_mask, 4'h1);
      chk("hold_busy", io_busy, 1);
      chk($sformatf("hold%0d_disable", i), dis, i != 1 && i != 2);
      if (i == 2) begin
        chk("hold_sram_memwe", mem_we, 1);
        chk("hold_sram_memaddr", mem_addr, 30'h100);
      end
      tick;
    end
    drive(1, 32'hFF000020, 32'hA5, 4'h3, 0, 1);
    chk("ack_ioreq", io_req, 1);
    chk("ack_disable", dis, 1);
    tick;
    drive(1, 32'hFF000020, 32'hA5, 4'h3, 0, 0);
    chk("post_ack_busy", io_busy, 0);
    chk("post_ack_ioreq", io_req, 0);
    chk("io2_accept_disable", dis, 0);
    tick;
    drive(0, 32'h0, 32'h0, 4'h0, 0, 0);
    chk("io2_busy", io_busy, 1);
    chk("io2_drain_ioreq", io_req, 0);
    tick;
    chk("io2_ioreq", io_req, 1);
    chk("io2_ioaddr", io_addr, 32'hFF000020);
    chk("io2_iodata", io_data, 32'hA5);
    chk("io2_iomask", io_mask, 4'h3);
    rst_n = 1'b0;
    drive(1, 32'hFF000030, 32'h1, 4'hF, 0, 0);
    chk("rst_req_disable", dis, 0);
    tick;
    chk("rst_req_ioreq", io_req, 0);
    chk("rst_req_busy", io_busy, 0);
    chk("rst_req_memwe", mem_we, 0);
    rst_n = 1'b1;
    drive(0, 32'h0, 32'h0, 4'h0, 0, 1);
    chk("late_ack_ioreq", io_req, 0);
    tick;
    chk("late_ack_busy", io_busy, 0);
    chk("late_ack_ioreq2", io_req, 0);
    drive(1, 32'h500, 32'h9, 4'hF, 1, 0);
    tick;
    rst_n = 1'b0;
    drive(0, 32'h0, 32'h0, 4'h0, 1, 0);
    tick;
    rst_n = 1'b1;
    drive(0, 32'h0, 32'h0, 4'h0, 0, 0);
    chk("rst_flush_memwe", mem_we, 0);
    drive(1, 32'h2000, 32'h11, 4'h1, 1, 0);
    tick;
    drive(1, 32'h2002, 32'h00330000, 4'h4, 1, 0);
    chk("merge_disable", dis, 0);
    tick;
    drive(0, 32'h0, 32'h0, 4'h0, 0, 0);
    chk("merge_w1_memwe", mem_we, 1);
    chk("merge_w1_memaddr", mem_addr, 30'h800);
`ifdef STORE_MERGE_EN
    chk("merge_w1_memdata", mem_data, 32'h00330011);
    chk("merge_w1_memmask", mem_mask, 4'h5);
    tick;
    chk("merge_done_memwe", mem_we, 0);
`else
    chk("merge_w1_memdata", mem_data, 32'h11);
    chk("merge_w1_memmask", mem_mask, 4'h1);
    tick;
    chk("merge_w2_memwe", mem_we, 1);
    chk("merge_w2_memaddr", mem_addr, 30'h800);
    chk("merge_w2_memdata", mem_data, 32'h00330000);
    chk("merge_w2_memmask", mem_mask, 4'h4);
    tick;
    chk("merge_done_memwe", mem_we, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
